// File: rtl/mem_sram_ctrl_if.sv
// mem_sram_ctrl_if: fetch/data request bus plus async SRAM pad signals
interface mem_sram_ctrl_if #(parameter int ADDR_W = 18);
    logic [31:0]       inst_addr;
    logic [31:0]       inst_out;
    logic              inst_ready;
    logic [31:0]       data_addr;
    logic [31:0]       data_wdata;
    logic [3:0]        data_be;
    logic              data_read;
    logic              data_write;
    logic [31:0]       data_rdata;
    logic              data_ready;
    logic [ADDR_W-1:0] sram_addr;
    logic [31:0]       sram_dq_o;
    logic [31:0]       sram_dq_i;
    logic              sram_dq_oe;
    logic              sram_ce_n;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic [3:0]        sram_be_n;
    modport master (
        output inst_addr, data_addr, data_wdata, data_be, data_read, data_write, sram_dq_i,
        input  inst_out, inst_ready, data_rdata, data_ready,
               sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
    );
    modport slave (
        input  inst_addr, data_addr, data_wdata, data_be, data_read, data_write, sram_dq_i,
        output inst_out, inst_ready, data_rdata, data_ready,
               sram_addr, sram_dq_o, sram_dq_oe, sram_ce_n, sram_oe_n, sram_we_n, sram_be_n
    );
endinterface

// File: rtl/mem_sram_ctrl.sv
// mem_sram_ctrl: serves data load/store then instruction fetch over one async SRAM, completing both together
module mem_sram_ctrl #(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 18
) (
    input logic           clk,
    input logic           rst,
    mem_sram_ctrl_if.slave bus
);
    if (WAIT_CYCLES < 2) begin : g_bad_wait
        $error("mem_sram_ctrl: WAIT_CYCLES must be 2 or more");
    end

    localparam int CW = $clog2(WAIT_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(WAIT_CYCLES - 1);
    localparam logic [CW-1:0] PRE  = CW'(WAIT_CYCLES - 2);

    typedef enum logic [2:0] {IDLE, D_RD, D_WR, I_RD, DONE} state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          op_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            op_data        <= 1'b0;
            bus.inst_ready <= 1'b0;
            bus.data_ready <= 1'b0;
            bus.inst_out   <= '0;
            bus.data_rdata <= '0;
            bus.sram_addr  <= '0;
            bus.sram_dq_o  <= '0;
            bus.sram_dq_oe <= 1'b0;
            bus.sram_ce_n  <= 1'b1;
            bus.sram_oe_n  <= 1'b1;
            bus.sram_we_n  <= 1'b1;
            bus.sram_be_n  <= 4'hF;
        end else begin
            bus.inst_ready <= 1'b0;
            bus.data_ready <= 1'b0;
            case (state)
                IDLE: begin
                    cnt           <= '0;
                    bus.sram_ce_n <= 1'b0;
                    if (bus.data_read || bus.data_write) begin
                        op_data       <= 1'b1;
                        bus.sram_addr <= bus.data_addr[ADDR_W+1:2];
                        if (bus.data_write) begin
                            state          <= D_WR;
                            bus.sram_dq_o  <= bus.data_wdata;
                            bus.sram_dq_oe <= 1'b1;
                            bus.sram_oe_n  <= 1'b1;
                            bus.sram_we_n  <= 1'b0;
                            bus.sram_be_n  <= ~bus.data_be;
                        end else begin
                            state         <= D_RD;
                            bus.sram_oe_n <= 1'b0;
                            bus.sram_be_n <= 4'h0;
                        end
                    end else begin
                        state         <= I_RD;
                        op_data       <= 1'b0;
                        bus.sram_addr <= bus.inst_addr[ADDR_W+1:2];
                        bus.sram_oe_n <= 1'b0;
                        bus.sram_be_n <= 4'h0;
                    end
                end
                D_RD, D_WR: begin
                    if (cnt == LAST) begin
                        state          <= I_RD;
                        cnt            <= '0;
                        bus.sram_addr  <= bus.inst_addr[ADDR_W+1:2];
                        bus.sram_dq_oe <= 1'b0;
                        bus.sram_oe_n  <= 1'b0;
                        bus.sram_we_n  <= 1'b1;
                        bus.sram_be_n  <= 4'h0;
                        if (state == D_RD) bus.data_rdata <= bus.sram_dq_i;
                    end else begin
                        cnt <= cnt + 1'b1;
                        // last write cycle releases we_n while data stays on the bus
                        if (state == D_WR) bus.sram_we_n <= (cnt == PRE);
                    end
                end
                I_RD: begin
                    if (cnt == LAST) begin
                        state          <= DONE;
                        bus.inst_out   <= bus.sram_dq_i;
                        bus.inst_ready <= 1'b1;
                        bus.data_ready <= op_data;
                        bus.sram_ce_n  <= 1'b1;
                        bus.sram_oe_n  <= 1'b1;
                        bus.sram_be_n  <= 4'hF;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_sram_ctrl.sv
// tb_mem_sram_ctrl: directed checks of fetch, load, store, reset abort and address wrap
module tb_mem_sram_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_sram_ctrl_if #(.ADDR_W(18)) bus ();
    mem_sram_ctrl #(.WAIT_CYCLES(2), .ADDR_W(18)) dut (.clk(clk), .rst(rst), .bus(bus));

    logic [31:0] mem [0:255];
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          n;
    int          last_rdy;
    logic [15:0] ir_v, dr_v, we_v, oe_v;
    logic [17:0] a1;
    logic [3:0]  be1;

    assign bus.sram_dq_i = (!bus.sram_ce_n && !bus.sram_oe_n) ? mem[bus.sram_addr[7:0]] : 32'h0BAD0BAD;

    always @(posedge clk)
        if (!bus.sram_ce_n && !bus.sram_we_n && bus.sram_dq_oe)
            for (int i = 0; i < 4; i++)
                if (!bus.sram_be_n[i]) mem[bus.sram_addr[7:0]][8*i +: 8] = bus.sram_dq_o[8*i +: 8];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // called in the IDLE cycle; returns in the DONE cycle (or after a bounded wait)
    task automatic run(input string tag, input int exp_n);
        n = 0;
        ir_v = '0; dr_v = '0; we_v = '0; oe_v = '0;
        do begin
            tick();
            n++;
            ir_v[n] = bus.inst_ready;
            dr_v[n] = bus.data_ready;
            we_v[n] = ~bus.sram_we_n;
            oe_v[n] = bus.sram_dq_oe;
            if (n == 1) begin
                a1  = bus.sram_addr;
                be1 = bus.sram_be_n;
            end
        end while (!bus.inst_ready && n < 12);
        check({tag, "_lat"}, 32'(n), 32'(exp_n));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        mem[0]   = 32'h3C011234;
        mem[1]   = 32'h20020005;
        mem[2]   = 32'h8C220010;
        mem[3]   = 32'h00000013;
        mem[4]   = 32'hDEADBEEF;
        mem[8]   = 32'h11223344;
        mem[255] = 32'hCAFEF00D;
        bus.inst_addr  = '0;
        bus.data_addr  = '0;
        bus.data_wdata = '0;
        bus.data_be    = '0;
        bus.data_read  = 1'b0;
        bus.data_write = 1'b0;
        repeat (3) tick();
        check("rst_strobes", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe, bus.sram_be_n}), 32'hEF);
        check("rst_rdy", 32'({bus.inst_ready, bus.data_ready}), 32'h0);
        check("rst_inst_out", bus.inst_out, 32'h0);
        check("rst_rdata", bus.data_rdata, 32'h0);
        check("rst_addr", 32'(bus.sram_addr), 32'h0);
        rst = 1'b0;

        run("fetch", 3);
        check("fetch_ir", 32'(ir_v), 32'h0008);
        check("fetch_dr", 32'(dr_v), 32'h0);
        check("fetch_inst", bus.inst_out, 32'h3C011234);
        check("fetch_addr", 32'(a1), 32'h0);

        bus.data_addr = 32'h10; bus.data_read = 1'b1; bus.inst_addr = 32'h8;
        tick();
        run("load", 5);
        check("load_ir", 32'(ir_v), 32'h0020);
        check("load_dr", 32'(dr_v), 32'h0020);
        check("load_rdata", bus.data_rdata, 32'hDEADBEEF);
        check("load_inst", bus.inst_out, 32'h8C220010);
        check("load_addr", 32'(a1), 32'h4);
        bus.data_read = 1'b0;

        bus.data_addr = 32'h20; bus.data_wdata = 32'hAABBCCDD; bus.data_be = 4'b0011;
        bus.data_write = 1'b1; bus.inst_addr = 32'hC;
        tick();
        run("store", 5);
        check("store_we", 32'(we_v), 32'h0002);
        check("store_oe", 32'(oe_v), 32'h0006);
        check("store_be", 32'(be1), 32'hC);
        check("store_mem", mem[8], 32'h1122CCDD);
        check("store_dr", 32'(dr_v), 32'h0020);
        check("store_rdata", bus.data_rdata, 32'hDEADBEEF);
        check("store_inst", bus.inst_out, 32'h00000013);

        bus.data_read = 1'b1; bus.data_addr = 32'h24; bus.data_wdata = 32'h55667788;
        bus.data_be = 4'hF; bus.inst_addr = 32'h0;
        tick();
        run("rdwr", 5);
        check("rdwr_we", 32'(we_v), 32'h0002);
        check("rdwr_oe", 32'(oe_v), 32'h0006);
        check("rdwr_be", 32'(be1), 32'h0);
        check("rdwr_mem", mem[9], 32'h55667788);
        check("rdwr_rdata", bus.data_rdata, 32'hDEADBEEF);
        bus.data_read = 1'b0; bus.data_write = 1'b0;

        bus.inst_addr = 32'h4;
        tick();
        tick();
        check("abort_active", 32'(bus.sram_ce_n), 32'h0);
        rst = 1'b1;
        tick();
        check("abort_strobes", 32'({bus.sram_ce_n, bus.sram_oe_n, bus.sram_we_n, bus.sram_dq_oe, bus.sram_be_n}), 32'hEF);
        check("abort_rdy", 32'({bus.inst_ready, bus.data_ready}), 32'h0);
        check("abort_inst_out", bus.inst_out, 32'h0);
        check("abort_rdata", bus.data_rdata, 32'h0);
        check("abort_addr", 32'(bus.sram_addr), 32'h0);
        rst = 1'b0;
        run("restart", 3);
        check("restart_ir", 32'(ir_v), 32'h0008);
        check("restart_inst", bus.inst_out, 32'h20020005);

        bus.inst_addr = 32'h0;
        tick();
        run("b2b0", 3);
        check("b2b0_inst", bus.inst_out, 32'h3C011234);
        last_rdy = cyc;
        bus.inst_addr = 32'h4;
        tick();
        run("b2b1", 3);
        check("b2b1_period", 32'(cyc - last_rdy), 32'd4);
        check("b2b1_inst", bus.inst_out, 32'h20020005);
        last_rdy = cyc;
        bus.inst_addr = 32'h8;
        tick();
        run("b2b2", 3);
        check("b2b2_period", 32'(cyc - last_rdy), 32'd4);
        check("b2b2_inst", bus.inst_out, 32'h8C220010);

        bus.inst_addr = 32'h000FFFFC;
        tick();
        run("top", 3);
        check("top_addr", 32'(a1), 32'h3FFFF);
        check("top_inst", bus.inst_out, 32'hCAFEF00D);

        bus.inst_addr = 32'h00100013;
        tick();
        run("wrap", 3);
        check("wrap_addr", 32'(a1), 32'h4);
        check("wrap_inst", bus.inst_out, 32'hDEADBEEF);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
